// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and trap detection for the shared-ALU scheduler.
package alu_pkg;

   localparam logic [2:0] OP_SUM  = 3'b000;
   localparam logic [2:0] OP_RES  = 3'b001;
   localparam logic [2:0] OP_PROD = 3'b010;
   localparam logic [2:0] OP_DIV  = 3'b011;
   localparam logic [2:0] OP_MOD  = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Ops answered with an error instead of occupying the ALU.
   function automatic logic is_trap(input logic [2:0] op, input logic [7:0] b);
      return (op > OP_MOD) || (((op == OP_DIV) || (op == OP_MOD)) && (b == 8'h00));
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid index at or after ptr, circularly.
module rr_arbiter #(
   parameter  int NUM_REQ = 2,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               found
);

   always_comb begin
      int j;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = (int'(ptr) + i) % NUM_REQ;
         if (!found && valid[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/alu_sched_top.sv
// Schedules NUM_REQ requesters onto one external combinational ALU and returns
// tagged results on a single backpressured response channel.
module alu_sched_top
   import alu_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   parameter  int ALU_LAT = 1,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   input  logic [3*NUM_REQ-1:0] req_ctrl_i,
   input  logic [8*NUM_REQ-1:0] req_data0_i,
   input  logic [8*NUM_REQ-1:0] req_data1_i,
   output logic [2:0]           alu_ctrl_o,
   output logic [7:0]           alu_data0_o,
   output logic [7:0]           alu_data1_o,
   input  logic [7:0]           alu_result_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [ID_W-1:0]      rsp_id_o,
   output logic [7:0]           rsp_result_o,
   output logic                 rsp_err_o,
   output logic                 busy_o
);

   localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   state_t               state, state_nxt;
   logic [ID_W-1:0]      ptr;
   logic [ID_W-1:0]      gnt_idx;
   logic [NUM_REQ-1:0]   gnt;
   logic                 gnt_any;
   logic [CNT_W-1:0]     cnt;
   logic [2:0]           sel_op;
   logic [7:0]           sel_a, sel_b;
   logic                 sel_trap;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .valid (req_valid_i),
      .ptr   (ptr),
      .grant (gnt),
      .idx   (gnt_idx),
      .found (gnt_any)
   );

   assign sel_op   = req_ctrl_i[3*int'(gnt_idx) +: 3];
   assign sel_a    = req_data0_i[8*int'(gnt_idx) +: 8];
   assign sel_b    = req_data1_i[8*int'(gnt_idx) +: 8];
   assign sel_trap = is_trap(sel_op, sel_b);

   assign req_ready_o = (state == S_IDLE) ? gnt : '0;
   assign rsp_valid_o = (state == S_RESP);
   assign busy_o      = (state != S_IDLE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (gnt_any) state_nxt = sel_trap ? S_RESP : S_EXEC;
         S_EXEC:  if (cnt == '0) state_nxt = S_RESP;
         S_RESP:  if (rsp_ready_i) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ALU drive regs are only written on a non-trapped grant, so they stay quiet otherwise.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr          <= '0;
         cnt          <= '0;
         alu_ctrl_o   <= '0;
         alu_data0_o  <= '0;
         alu_data1_o  <= '0;
         rsp_id_o     <= '0;
         rsp_result_o <= '0;
         rsp_err_o    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (gnt_any) begin
                  ptr      <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
                  rsp_id_o <= gnt_idx;
                  if (sel_trap) begin
                     rsp_err_o    <= 1'b1;
                     rsp_result_o <= 8'h00;
                  end else begin
                     alu_ctrl_o  <= sel_op;
                     alu_data0_o <= sel_a;
                     alu_data1_o <= sel_b;
                     cnt         <= CNT_W'(ALU_LAT-1);
                  end
               end
            end
            S_EXEC: begin
               if (cnt == '0) begin
                  rsp_result_o <= alu_result_i;
                  rsp_err_o    <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
